// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes the immediate field of a 32-bit ARMv8 instruction word
// and extends it to XLEN bits. Results are queued in a 2-entry FIFO with
// valid/ready handshakes on both sides. in_ready depends only on the
// registered occupancy, so decode never sees a combinational path from execute.
// Optional feature macro: SEU_ERR_CNT_EN adds the err_count port, which counts
// accepted reserved-mode and unrepresentable MOVimm requests.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [31:0]      in_ins,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_value,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef SEU_ERR_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam logic [2:0] MODE_ALUIMM = 3'b000;
  localparam logic [2:0] MODE_BR     = 3'b001;
  localparam logic [2:0] MODE_CB     = 3'b010;
  localparam logic [2:0] MODE_DT     = 3'b011;
  localparam logic [2:0] MODE_MOV    = 3'b100;
  localparam logic [2:0] MODE_LDST   = 3'b101;
  localparam logic [2:0] MODE_ADR    = 3'b110;

  // Instruction bits [28:26] are not part of any immediate format.
  logic unused_ins_bits;
  assign unused_ins_bits = ^in_ins[28:26];

  logic [63:0]      wide_d;
  logic [XLEN-1:0]  dec_value_d;
  logic             dec_illegal_d;

  logic             push;
  logic             pop;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;

  // Decode the immediate at full 64-bit width, then truncate to XLEN.
  always_comb begin
    wide_d        = '0;
    dec_illegal_d = 1'b0;
    case (in_mode)
      MODE_ALUIMM: wide_d = in_ins[22] ? {40'b0, in_ins[21:10], 12'b0}
                                       : {52'b0, in_ins[21:10]};
      MODE_BR:     wide_d = {{36{in_ins[25]}}, in_ins[25:0], 2'b00};
      MODE_CB:     wide_d = {{43{in_ins[23]}}, in_ins[23:5], 2'b00};
      MODE_DT:     wide_d = {{55{in_ins[20]}}, in_ins[20:12]};
      MODE_MOV: begin
        // hw=2/3 would place the halfword above bit 31 of a 32-bit result.
        if ((XLEN == 32) && in_ins[22]) dec_illegal_d = 1'b1;
        else wide_d = {48'b0, in_ins[20:5]} << {in_ins[22:21], 4'b0000};
      end
      MODE_LDST:   wide_d = {52'b0, in_ins[21:10]} << in_ins[31:30];
      MODE_ADR:    wide_d = {{43{in_ins[23]}}, in_ins[23:5], in_ins[30:29]};
      default:     dec_illegal_d = 1'b1;
    endcase
  end

  assign dec_value_d = wide_d[XLEN-1:0];

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for occupancy and the read/write pointers.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy and pointer registers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // One storage slot per FIFO entry, written when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [XLEN-1:0]  val_q;
    logic [TAG_W-1:0] tag_q;
    logic             ill_q;

    // Capture the decoded result into this slot on an accepted push.
    always_ff @(posedge clk) begin
      if (reset) begin
        val_q <= '0;
        tag_q <= '0;
        ill_q <= 1'b0;
      end else if (push && (wr_ptr_q == 1'(gi))) begin
        val_q <= dec_value_d;
        tag_q <= in_tag;
        ill_q <= dec_illegal_d;
      end
    end
  end

  assign out_value   = rd_ptr_q ? g_entry[1].val_q : g_entry[0].val_q;
  assign out_tag     = rd_ptr_q ? g_entry[1].tag_q : g_entry[0].tag_q;
  assign out_illegal = rd_ptr_q ? g_entry[1].ill_q : g_entry[0].ill_q;

`ifdef SEU_ERR_CNT_EN
  logic [15:0] err_q;

  // Saturating count of accepted illegal requests; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 16'd0;
    end else if (push && dec_illegal_d && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven directed vectors, hand-written handshake
// sequences and a randomized phase, all checked against a queue-based
// reference model. Runs a 64-bit and a 32-bit instance side by side.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_mode;
  logic [31:0] in_ins;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_value64;
  logic [4:0]  out_tag64;
  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_value32;
  logic [4:0]  out_tag32;
`ifdef SEU_ERR_CNT_EN
  logic [15:0] err_count64, err_count32;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_mode(in_mode), .in_ins(in_ins), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_value(out_value64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
`ifdef SEU_ERR_CNT_EN
    , .err_count(err_count64)
`endif
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_mode(in_mode), .in_ins(in_ins), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_value(out_value32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
`ifdef SEU_ERR_CNT_EN
    , .err_count(err_count32)
`endif
  );

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] ins;
    logic [4:0]  tag;
    logic [63:0] v64;
    logic        i64;
    logic [31:0] v32;
    logic        i32;
  } vec_t;

  typedef struct {
    logic [63:0] v64;
    logic        i64;
    logic [63:0] v32;
    logic        i32;
    logic [4:0]  tag;
  } ent_t;

  vec_t vecs[9];
  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;
  int   err64_m = 0;
  int   err32_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint sext(input longint f, input int w);
    if (f >= (longint'(1) << (w - 1))) return f - (longint'(1) << w);
    return f;
  endfunction

  // Reference decode written from the format rules using plain arithmetic.
  function automatic void ref_decode(input logic [2:0] mode, input logic [31:0] ins,
                                     input int xlen, output logic [63:0] v, output logic ill);
    longint r;
    int hw;
    r   = 0;
    ill = 1'b0;
    hw  = int'(ins[22:21]);
    case (mode)
      3'd0: r = longint'(ins[21:10]) * (ins[22] ? 4096 : 1);
      3'd1: r = sext(longint'(ins[25:0]), 26) * 4;
      3'd2: r = sext(longint'(ins[23:5]), 19) * 4;
      3'd3: r = sext(longint'(ins[20:12]), 9);
      3'd4: if (xlen == 32 && hw >= 2) ill = 1'b1;
            else r = longint'(ins[20:5]) * (longint'(1) << (16 * hw));
      3'd5: r = longint'(ins[21:10]) * (1 << int'(ins[31:30]));
      3'd6: r = sext(longint'(ins[23:5]) * 4 + longint'(ins[30:29]), 21);
      default: ill = 1'b1;
    endcase
    v = ill ? 64'd0 : 64'(r);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Advance one clock, update the model with the handshakes seen at the edge,
  // then compare both instances against the model head.
  task automatic step();
    bit   push, pop;
    ent_t e;
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() != 0) && out_ready;
    ref_decode(in_mode, in_ins, 64, e.v64, e.i64);
    ref_decode(in_mode, in_ins, 32, e.v32, e.i32);
    e.tag = in_tag;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      err64_m = 0;
      err32_m = 0;
    end else begin
      if (pop) begin
        $display("pop  tag=%0d v64=%h ill64=%0b v32=%h ill32=%0b",
                 mq[0].tag, mq[0].v64, mq[0].i64, mq[0].v32[31:0], mq[0].i32);
        void'(mq.pop_front());
      end
      if (push) begin
        mq.push_back(e);
        if (e.i64 && err64_m < 65535) err64_m++;
        if (e.i32 && err32_m < 65535) err32_m++;
      end
    end
    #1;
    chk("out_valid64", 64'(out_valid64), 64'(mq.size() != 0));
    chk("out_valid32", 64'(out_valid32), 64'(mq.size() != 0));
    chk("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
    chk("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
    if (mq.size() != 0) begin
      chk("value64", out_value64, mq[0].v64);
      chk("illegal64", 64'(out_illegal64), 64'(mq[0].i64));
      chk("tag64", 64'(out_tag64), 64'(mq[0].tag));
      chk("value32", 64'(out_value32), mq[0].v32);
      chk("illegal32", 64'(out_illegal32), 64'(mq[0].i32));
      chk("tag32", 64'(out_tag32), 64'(mq[0].tag));
    end
`ifdef SEU_ERR_CNT_EN
    chk("err_count64", 64'(err_count64), 64'(err64_m));
    chk("err_count32", 64'(err_count32), 64'(err32_m));
`endif
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] ins,
                       input logic [4:0] tag);
    in_valid = v;
    in_mode  = m;
    in_ins   = ins;
    in_tag   = tag;
  endtask

  initial begin
    vecs[0] = '{3'd1, 32'h03FF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[1] = '{3'd0, 32'h006A_F000, 5'd2, 64'h0000_0000_00AB_C000, 1'b0, 32'h00AB_C000, 1'b0};
    vecs[2] = '{3'd4, 32'h0062_4680, 5'd3, 64'h1234_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{3'd4, 32'h0042_4680, 5'd4, 64'h0000_1234_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{3'd3, 32'h0010_0000, 5'd5, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
    vecs[5] = '{3'd2, 32'h0000_0020, 5'd6, 64'h0000_0000_0000_0004, 1'b0, 32'h0000_0004, 1'b0};
    vecs[6] = '{3'd5, 32'hC03F_FC00, 5'd7, 64'h0000_0000_0000_7FF8, 1'b0, 32'h0000_7FF8, 1'b0};
    vecs[7] = '{3'd6, 32'h2080_0000, 5'd8, 64'hFFFF_FFFF_FFF0_0001, 1'b0, 32'hFFF0_0001, 1'b0};
    vecs[8] = '{3'd7, 32'h1234_5678, 5'd9, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1};

    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    step();
    step();
    reset = 1'b0;
    chk("reset out_value64", out_value64, 64'd0);
    chk("reset out_tag64", 64'(out_tag64), 64'd0);
    chk("reset out_illegal64", 64'(out_illegal64), 64'd0);
    chk("reset in_ready64", 64'(in_ready64), 64'd1);
    step();

    // Directed table: with out_ready high the head is always the last push.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].ins, vecs[i].tag);
      step();
      chk($sformatf("tbl%0d value64", i), out_value64, vecs[i].v64);
      chk($sformatf("tbl%0d illegal64", i), 64'(out_illegal64), 64'(vecs[i].i64));
      chk($sformatf("tbl%0d value32", i), 64'(out_value32), 64'(vecs[i].v32));
      chk($sformatf("tbl%0d illegal32", i), 64'(out_illegal32), 64'(vecs[i].i32));
      chk($sformatf("tbl%0d tag", i), 64'(out_tag64), 64'(vecs[i].tag));
    end
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    step();

    // Backpressure: three back-to-back pushes into a stalled consumer.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h0000_0400, 5'd1);
    step();
    drive(1'b1, 3'd0, 32'h0000_0800, 5'd2);
    step();
    chk("bp in_ready after 2", 64'(in_ready64), 64'd0);
    drive(1'b1, 3'd0, 32'h0000_0C00, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp head stable tag", 64'(out_tag64), 64'd1);
      chk("bp head stable value", out_value64, 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp drain tag2", 64'(out_tag64), 64'd2);
    step();
    chk("bp drain tag3", 64'(out_tag64), 64'd3);
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    step();
    chk("bp empty", 64'(out_valid64), 64'd0);

    // Simultaneous push and pop at count 1 replaces the head.
    out_ready = 1'b0;
    drive(1'b1, 3'd5, 32'h4000_0400, 5'd5);
    step();
    out_ready = 1'b1;
    drive(1'b1, 3'd5, 32'h8000_0400, 5'd9);
    step();
    chk("pp out_valid", 64'(out_valid64), 64'd1);
    chk("pp in_ready", 64'(in_ready64), 64'd1);
    chk("pp head tag", 64'(out_tag64), 64'd9);
    chk("pp head value", out_value64, 64'd4);
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    step();

`ifdef SEU_ERR_CNT_EN
    // Reserved mode three times from a freshly reset counter.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd7, $urandom, 5'(i));
      step();
    end
    chk("err_count64 x3", 64'(err_count64), 64'd3);
    chk("err_count32 x3", 64'(err_count32), 64'd3);
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    step();
`endif

    // Reset while full with a push offered: everything is dropped.
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 32'h0000_0010, 5'd10);
    step();
    drive(1'b1, 3'd1, 32'h0000_0020, 5'd11);
    step();
    reset = 1'b1;
    drive(1'b1, 3'd1, 32'h0000_0030, 5'd12);
    step();
    chk("rst out_valid", 64'(out_valid64), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst no stale", 64'(out_valid64), 64'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom, 5'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    out_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
